// File: rtl/game_sequencer.sv
// Game step sequencer: start countdown, a play phase whose tick period shrinks
// after each successful step, a death flash, and a score hold. Spawns lanes from an LFSR.
module game_sequencer #(
    parameter int BASE_PERIOD = 50000000,
    parameter int STEP        = 51113,
    parameter int MIN_PERIOD  = 5000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        miss,
    output logic        tick,
    output logic [2:0]  state,
    output logic        clear,
    output logic [1:0]  lane_req,
    output logic        blink,
    output logic [31:0] period,
    output logic [7:0]  level
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CNT3  = 3'd1,
        CNT2  = 3'd2,
        CNT1  = 3'd3,
        CLEAR = 3'd4,
        PLAY  = 3'd5,
        DEAD  = 3'd6,
        SCORE = 3'd7
    } state_t;

    localparam logic [31:0] BASE_W    = 32'(BASE_PERIOD);
    localparam logic [31:0] STEP_W    = 32'(STEP);
    localparam logic [31:0] MIN_W     = 32'(MIN_PERIOD);
    // Sum in 33 bits so the clamp test itself can never wrap.
    localparam logic [32:0] CLAMP_LIM = {1'b0, MIN_W} + {1'b0, STEP_W};

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period_q, period_d;
    logic [7:0]  level_q, level_d;
    logic        blink_q, blink_d;
    logic [3:0]  lfsr_q, lfsr_d;
    logic        start_q, start_d;
    logic        armed_q, armed_d;

    logic sedge;
    logic active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= BASE_W;
            level_q  <= '0;
            blink_q  <= 1'b0;
            lfsr_q   <= 4'b0001;
            start_q  <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            level_q  <= level_d;
            blink_q  <= blink_d;
            lfsr_q   <= lfsr_d;
            start_q  <= start_d;
            armed_q  <= armed_d;
        end
    end

    always_comb begin
        // armed_q blocks a start held high through reset from counting as an edge.
        sedge    = start && !start_q && armed_q;
        active   = (state_q != IDLE) && (state_q != SCORE);
        tick     = active && (cnt_q == period_q - 32'd1);
        clear    = tick && (state_q == CLEAR);
        lane_req = (tick && (state_q == PLAY) && !miss) ? lfsr_q[1:0] : 2'd0;

        state_d  = state_q;
        cnt_d    = '0;
        period_d = period_q;
        level_d  = level_q;
        blink_d  = blink_q;
        lfsr_d   = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        start_d  = start;
        armed_d  = armed_q | ~start;

        if (active) begin
            cnt_d = tick ? 32'd0 : cnt_q + 32'd1;
        end

        if (sedge) begin
            cnt_d = '0;
            if (active) begin
                state_d = SCORE;
            end else begin
                state_d  = CNT3;
                period_d = BASE_W;
            end
        end else if (tick) begin
            case (state_q)
                CNT3: state_d = CNT2;
                CNT2: state_d = CNT1;
                CNT1: state_d = CLEAR;
                CLEAR: begin
                    state_d = PLAY;
                    level_d = '0;
                    blink_d = 1'b0;
                end
                PLAY: begin
                    if (miss) begin
                        state_d  = DEAD;
                        period_d = BASE_W;
                    end else begin
                        period_d = ({1'b0, period_q} < CLAMP_LIM) ? MIN_W : period_q - STEP_W;
                        if (level_q != 8'hFF) level_d = level_q + 8'd1;
                    end
                end
                DEAD: blink_d = ~blink_q;
                default: ;
            endcase
        end

        if (state_d != DEAD) blink_d = 1'b0;
    end

    assign state  = state_q;
    assign blink  = blink_q;
    assign period = period_q;
    assign level  = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed stimulus pushes expected tick records,
// a negedge monitor pops and checks them whenever the DUT ticks.
module tb_game_sequencer;

    localparam int BP = 20;
    localparam int ST = 3;
    localparam int MP = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        miss;
    logic        tick;
    logic [2:0]  state;
    logic        clear;
    logic [1:0]  lane_req;
    logic        blink;
    logic [31:0] period;
    logic [7:0]  level;

    game_sequencer #(.BASE_PERIOD(BP), .STEP(ST), .MIN_PERIOD(MP)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .miss(miss),
        .tick(tick), .state(state), .clear(clear), .lane_req(lane_req),
        .blink(blink), .period(period), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic       clr;
        int         gap;
        logic       lane_chk;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] tab [0:14];
    int   ncyc;

    initial begin
        tab[0]  = 4'b0001; tab[1]  = 4'b0010; tab[2]  = 4'b0100; tab[3]  = 4'b1001;
        tab[4]  = 4'b0011; tab[5]  = 4'b0110; tab[6]  = 4'b1101; tab[7]  = 4'b1010;
        tab[8]  = 4'b0101; tab[9]  = 4'b1011; tab[10] = 4'b0111; tab[11] = 4'b1111;
        tab[12] = 4'b1110; tab[13] = 4'b1100; tab[14] = 4'b1000;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic clr, input int gap, input logic lc);
        exp_t e;
        e.st = st; e.clr = clr; e.gap = gap; e.lane_chk = lc;
        q.push_back(e);
    endtask

    task automatic push_countdown();
        push(3'd1, 1'b0, BP, 1'b0);
        push(3'd2, 1'b0, BP, 1'b0);
        push(3'd3, 1'b0, BP, 1'b0);
        push(3'd4, 1'b1, BP, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_pending", q.size(), 0);
        q.delete();
    endtask

    // Posedges since reset release index the hand-derived LFSR sequence.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    int         cyc = 0;
    int         last_tick = 0;
    logic [2:0] prev_st = 3'd0;

    always @(negedge clk) begin
        exp_t e;
        logic [1:0] lexp;
        if (!rst_n) begin
            prev_st = 3'd0;
        end else begin
            cyc++;
            if (state == 3'd1 && (prev_st == 3'd0 || prev_st == 3'd7)) last_tick = cyc - 1;
            if (tick) begin
                if (state == 3'd7) chk("score_tick", tick, 0);
                if (q.size() == 0) begin
                    chk("unexpected_tick_state", state, 3'd0);
                    errors++;
                    $display("FAIL unexpected_tick actual=1 expected=0 at %0t", $time);
                end else begin
                    e = q.pop_front();
                    lexp = e.lane_chk ? tab[ncyc % 15][1:0] : 2'd0;
                    chk("tick_state", state, e.st);
                    chk("tick_clear", clear, e.clr);
                    chk("tick_gap", cyc - last_tick, e.gap);
                    chk("tick_lane", lane_req, lexp);
                end
                last_tick = cyc;
            end else begin
                chk("offtick_lane", lane_req, 0);
                chk("offtick_clear", clear, 0);
            end
            prev_st = state;
        end
    end

    initial begin
        logic b;
        logic found;
        rst_n = 1'b0; start = 1'b0; miss = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_tick", tick, 0);
        chk("rst_clear", clear, 0);
        chk("rst_lane", lane_req, 0);
        chk("rst_blink", blink, 0);
        chk("rst_level", level, 0);
        chk("rst_period", period, BP);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Countdown, then accelerating play
        push_countdown();
        push(3'd5, 1'b0, 20, 1'b1); push(3'd5, 1'b0, 17, 1'b1);
        push(3'd5, 1'b0, 14, 1'b1); push(3'd5, 1'b0, 11, 1'b1);
        for (int i = 0; i < 4; i++) push(3'd5, 1'b0, 8, 1'b1);
        pulse_start();
        drain(3000);
        @(negedge clk); #1;
        chk("play_state", state, 5);
        chk("play_level", level, 8);
        chk("play_period_floor", period, MP);

        // Miss -> DEAD, blink toggles on each DEAD tick
        miss = 1'b1;
        push(3'd5, 1'b0, 8, 1'b0);
        drain(500);
        @(negedge clk); #1;
        chk("dead_state", state, 6);
        chk("dead_period", period, BP);
        chk("dead_level", level, 8);
        chk("dead_blink0", blink, 0);
        b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(3'd6, 1'b0, BP, 1'b0);
            drain(500);
            @(negedge clk); #1;
            b = ~b;
            chk("dead_blink", blink, b);
        end
        miss = 1'b0;
        pulse_start();
        @(negedge clk); #1;
        chk("score_state", state, 7);
        chk("score_blink", blink, 0);
        repeat (45) @(posedge clk);
        @(negedge clk); #1;
        chk("score_hold", state, 7);

        // Start edge coincident with the CNT2 tick aborts to SCORE
        push(3'd1, 1'b0, BP, 1'b0);
        push(3'd2, 1'b0, BP, 1'b0);
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (tick && state == 3'd2) begin
                found = 1'b1;
                break;
            end
        end
        chk("abort_sync", found, 1);
        pulse_start();
        @(negedge clk); #1;
        chk("abort_state", state, 7);
        chk("abort_queue", q.size(), 0);

        // Restart, play 5 steps, then reset mid-play with start held high
        push_countdown();
        push(3'd5, 1'b0, 20, 1'b1); push(3'd5, 1'b0, 17, 1'b1);
        push(3'd5, 1'b0, 14, 1'b1); push(3'd5, 1'b0, 11, 1'b1);
        push(3'd5, 1'b0, 8, 1'b1);
        pulse_start();
        @(negedge clk); #1;
        chk("restart_state", state, 1);
        chk("restart_period", period, BP);
        drain(3000);
        @(negedge clk); #1;
        chk("mid_level", level, 5);
        chk("mid_state", state, 5);
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_tick", tick, 0);
        chk("arst_clear", clear, 0);
        chk("arst_lane", lane_req, 0);
        chk("arst_blink", blink, 0);
        chk("arst_level", level, 0);
        chk("arst_period", period, BP);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        @(negedge clk); #1;
        chk("held_start_idle", state, 0);

        // Fresh game: 15 play steps exercising the full LFSR cycle
        start = 1'b0;
        @(posedge clk); #1;
        push_countdown();
        push(3'd5, 1'b0, 20, 1'b1); push(3'd5, 1'b0, 17, 1'b1);
        push(3'd5, 1'b0, 14, 1'b1); push(3'd5, 1'b0, 11, 1'b1);
        for (int i = 0; i < 11; i++) push(3'd5, 1'b0, 8, 1'b1);
        pulse_start();
        drain(5000);
        @(negedge clk); #1;
        chk("lane_level", level, 15);
        chk("lane_period", period, MP);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
